sine_phase_decoder: RTL and testbench

//  Receive-side counterpart of the sine LUT generator. Takes a stream of

---
 rtl/sine_phase_decoder.sv | 197 +++++++++++++++++++
 tb/tb_sine_phase_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_decoder.sv
// Recovers the 6-bit phase index from offset-sine samples (64 steps/cycle), measures the
// period between rising mid-crossings and reports lock once successive periods agree.
module sine_phase_decoder #(
    parameter int unsigned MID      = 1000,
    parameter int unsigned PER_W    = 16,
    parameter int unsigned LOCK_TOL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sample_in,
    input  logic             sample_valid,
    output logic [5:0]       phase,
    output logic             phase_valid,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             locked
);

    typedef enum logic [1:0] {StIdle, StPrime, StTrack, StLocked} state_e;

    localparam logic [15:0]      MidS   = 16'(MID);
    localparam logic [PER_W-1:0] CntMax = '1;
    localparam logic [PER_W-1:0] CntOne = PER_W'(1);
    localparam logic [PER_W-1:0] Tol    = PER_W'(LOCK_TOL);

    // First quadrant of 1000*sin, 16 steps
    localparam logic [11:0] QTAB [17] = '{
        12'd0,   12'd98,  12'd195, 12'd290, 12'd383, 12'd471, 12'd556, 12'd634, 12'd707,
        12'd773, 12'd831, 12'd882, 12'd924, 12'd957, 12'd981, 12'd995, 12'd1000
    };

    state_e           state_q, state_d;
    logic [15:0]      last_q;
    logic             slope_q;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] prev_per_q, prev_per_d;
    logic             have_per_q, have_per_d;
    logic             per_vld_d;
    logic [PER_W-1:0] per_diff;

    logic             have_prev;
    logic             rising_d;
    logic             crossing;

    logic             s1_vld_q;
    logic [15:0]      s1_sample_q;
    logic             s1_rising_q;
    logic             s1_per_vld_q;
    logic [PER_W-1:0] s1_per_q;
    logic             s1_locked_q;

    logic [15:0]      a_raw;
    logic [10:0]      a_sat;
    logic [4:0]       k;
    logic [5:0]       k6;
    logic             upper;
    logic [5:0]       phase_d;

    logic [5:0]       phase_q;
    logic             phase_valid_q;
    logic [PER_W-1:0] period_q;
    logic             period_valid_q;
    logic             locked_q;

    assign have_prev = (state_q != StIdle);
    assign crossing  = have_prev && (last_q < MidS) && (sample_in >= MidS);
    assign per_diff  = (cnt_q >= prev_per_q) ? (cnt_q - prev_per_q) : (prev_per_q - cnt_q);

    // Equal samples keep the previous slope
    always_comb begin
        rising_d = slope_q;
        if (have_prev) begin
            if (sample_in > last_q) begin
                rising_d = 1'b1;
            end else if (sample_in < last_q) begin
                rising_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_per_d = prev_per_q;
        have_per_d = have_per_q;
        per_vld_d  = 1'b0;
        if (sample_valid) begin
            unique case (state_q)
                StIdle: state_d = StPrime;
                StPrime: begin
                    if (crossing) begin
                        state_d = StTrack;
                        cnt_d   = CntOne;
                    end
                end
                StTrack, StLocked: begin
                    if (crossing) begin
                        per_vld_d  = 1'b1;
                        cnt_d      = CntOne;
                        state_d    = (have_per_q && per_diff <= Tol) ? StLocked : StTrack;
                        prev_per_d = cnt_q;
                        have_per_d = 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntOne;
                        // Saturation drops lock and forgets the period history
                        if (cnt_d == CntMax) begin
                            state_d    = StTrack;
                            have_per_d = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_q       <= '0;
            slope_q      <= 1'b0;
            cnt_q        <= '0;
            prev_per_q   <= '0;
            have_per_q   <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_sample_q  <= '0;
            s1_rising_q  <= 1'b0;
            s1_per_vld_q <= 1'b0;
            s1_per_q     <= '0;
            s1_locked_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_per_q   <= prev_per_d;
            have_per_q   <= have_per_d;
            s1_vld_q     <= sample_valid && have_prev;
            s1_per_vld_q <= per_vld_d;
            if (sample_valid) begin
                last_q      <= sample_in;
                slope_q     <= rising_d;
                s1_sample_q <= sample_in;
                s1_rising_q <= rising_d;
                s1_locked_q <= (state_d == StLocked);
            end
            if (per_vld_d) begin
                s1_per_q <= cnt_q;
            end
        end
    end

    always_comb begin
        upper = (s1_sample_q >= MidS);
        a_raw = upper ? (s1_sample_q - MidS) : (MidS - s1_sample_q);
        a_sat = (a_raw > 16'd1000) ? 11'd1000 : a_raw[10:0];
        // Nearest table entry: count midpoints strictly below a, so ties resolve low
        k = '0;
        for (int j = 0; j < 16; j++) begin
            if ({a_sat, 1'b0} > (QTAB[j] + QTAB[j+1])) begin
                k = k + 5'd1;
            end
        end
        k6 = {1'b0, k};
        unique case ({upper, s1_rising_q})
            2'b11:   phase_d = k6;
            2'b10:   phase_d = 6'd32 - k6;
            2'b00:   phase_d = 6'd32 + k6;
            default: phase_d = 6'd0 - k6;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q        <= '0;
            phase_valid_q  <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            phase_valid_q  <= s1_vld_q;
            period_valid_q <= s1_per_vld_q;
            locked_q       <= s1_locked_q;
            if (s1_vld_q) begin
                phase_q <= phase_d;
            end
            if (s1_per_vld_q) begin
                period_q <= s1_per_q;
            end
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_sine_phase_decoder.sv
// Directed bench for sine_phase_decoder: each step drives one cycle and checks the outputs
// belonging to the sample driven two steps earlier.
module tb_sine_phase_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [5:0]  phase;
    logic        phase_valid;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;

    int n_vec  = 0;
    int n_miss = 0;
    int qtab [17] = '{0, 98, 195, 290, 383, 471, 556, 634, 707, 773, 831, 882, 924, 957, 981,
                      995, 1000};

    typedef struct packed {
        logic        pv;
        logic [5:0]  ph;
        logic        perv;
        logic [15:0] per;
        logic        lk;
    } exp_t;

    exp_t pipe1, pipe2;
    logic cur_lk;

    localparam int SatM = (1 << 16) - 4;

    sine_phase_decoder #(.MID(1000), .PER_W(16), .LOCK_TOL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sine(input int idx);
        int p;
        p = idx % 64;
        if (p <= 16)      return 16'(1000 + qtab[p]);
        else if (p <= 32) return 16'(1000 + qtab[32 - p]);
        else if (p <= 48) return 16'(1000 - qtab[p - 32]);
        else              return 16'(1000 - qtab[64 - p]);
    endfunction

    task automatic check_zero(input string where);
        chk({where, ".phase"}, 32'(phase), 0);
        chk({where, ".phase_valid"}, 32'(phase_valid), 0);
        chk({where, ".period"}, 32'(period), 0);
        chk({where, ".period_valid"}, 32'(period_valid), 0);
        chk({where, ".locked"}, 32'(locked), 0);
    endtask

    task automatic step(input logic [15:0] s, input logic v, input logic epv,
                        input logic [5:0] eph, input logic eperv, input logic [15:0] eper,
                        input logic elk);
        @(negedge clk);
        chk("phase_valid", 32'(phase_valid), 32'(pipe2.pv));
        if (pipe2.pv) chk("phase", 32'(phase), 32'(pipe2.ph));
        chk("period_valid", 32'(period_valid), 32'(pipe2.perv));
        if (pipe2.perv) chk("period", 32'(period), 32'(pipe2.per));
        chk("locked", 32'(locked), 32'(pipe2.lk));
        pipe2 = pipe1;
        pipe1 = '{pv: epv, ph: eph, perv: eperv, per: eper, lk: elk};
        sample_in    = s;
        sample_valid = v;
    endtask

    task automatic feed(input logic [15:0] s, input logic epv, input logic [5:0] eph,
                        input logic eperv, input logic [15:0] eper, input logic elk);
        step(s, 1'b1, epv, eph, eperv, eper, elk);
        cur_lk = elk;
    endtask

    task automatic idle();
        step(16'($urandom), 1'b0, 1'b0, 6'd0, 1'b0, 16'd0, cur_lk);
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        pipe1 = '0;
        pipe2 = '0;
        cur_lk = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        #1;
        check_zero("reset");
        release_rst();
    endtask

    // Asynchronous reset asserted between clock edges: outputs clear without a clock
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        sample_valid = 1'b0;
        release_rst();
    endtask

    // Samples idx = 0, stride, ... up to last; crossings at idx 64/128/192, lock from 192
    task automatic run_seq(input int last, input int stride, input bit gaps);
        int idx;
        for (int j = 0; j * stride <= last; j++) begin
            idx = j * stride;
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle();
            feed(sine(idx), j > 0, 6'(idx % 64), (idx % 64 == 0) && idx >= 128,
                 16'(64 / stride), idx >= 192);
        end
    endtask

    initial begin
        pipe1 = '0;
        pipe2 = '0;
        cur_lk = 1'b0;

        // Test 1: one full cycle, first sample silent
        do_reset();
        run_seq(64, 1, 1'b0);
        idle(); idle();

        // Test 2: three back-to-back cycles, periods at crossings 2 and 3, lock at 3
        do_reset();
        run_seq(192, 1, 1'b0);
        idle(); idle();

        // Test 3: 16 samples per cycle
        do_reset();
        run_seq(192, 4, 1'b0);
        idle(); idle();

        // Test 4: test 2 stream with random invalid cycles, then reset while locked
        do_reset();
        run_seq(192, 1, 1'b1);
        idle(); idle();
        feed(sine(1), 1'b1, 6'd1, 1'b0, 16'd0, 1'b1);
        idle(); idle();
        mid_reset();

        // Test 5: reset mid cycle 2, then first post-reset sample stays silent
        run_seq(100, 1, 1'b0);
        mid_reset();
        feed(sine(10), 1'b0, 6'd0, 1'b0, 16'd0, 1'b0);
        feed(sine(11), 1'b1, 6'd11, 1'b0, 16'd0, 1'b0);
        feed(sine(12), 1'b1, 6'd12, 1'b0, 16'd0, 1'b0);
        idle(); idle();

        // Test 6: saturated amplitude, held slope, counter saturation drops lock
        do_reset();
        run_seq(192, 1, 1'b0);
        feed(16'd3000, 1'b1, 6'd16, 1'b0, 16'd0, 1'b1);
        feed(16'd3000, 1'b1, 6'd16, 1'b0, 16'd0, 1'b1);
        for (int m = 1; m <= 65536; m++) begin
            feed(16'd1000, 1'b1, 6'd32, 1'b0, 16'd0, m < SatM);
        end
        feed(16'd902, 1'b1, 6'd33, 1'b0, 16'd0, 1'b0);
        feed(16'd1000, 1'b1, 6'd0, 1'b1, 16'hffff, 1'b0);
        for (int p = 1; p < 64; p++) begin
            feed(sine(p), 1'b1, 6'(p), 1'b0, 16'd0, 1'b0);
        end
        feed(16'd1000, 1'b1, 6'd0, 1'b1, 16'd64, 1'b0);
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
